// File: rtl/edge_pattern_generator_if.sv
// Control/status bundle for the edge pattern generator.
// The master side requests bursts and observes the generated waveform.
// The slave side is the generator itself.
interface edge_pattern_generator_if #(
  parameter int CNT_W = 8,
  parameter int NUM_W = 8
);
  logic             start;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic [NUM_W-1:0] num_pulses;
  logic             abort;
  logic             ready;
  logic             busy;
  logic             dout;
  logic             edge_strobe;
  logic             done;

  modport master (
    output start, high_len, low_len, num_pulses, abort,
    input  ready, busy, dout, edge_strobe, done
  );

  modport slave (
    input  start, high_len, low_len, num_pulses, abort,
    output ready, busy, dout, edge_strobe, done
  );
endinterface

// File: rtl/edge_pattern_generator.sv
// Burst square-wave generator: N pulses of H cycles high followed by L cycles
// low, with a one-cycle strobe on every transition of dout and a done pulse
// when a burst completes normally. Zero lengths are treated as one cycle.
module edge_pattern_generator #(
  parameter int CNT_W = 8,
  parameter int NUM_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  edge_pattern_generator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
  logic [NUM_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [CNT_W-1:0] high_len_q, high_len_d;
  logic [CNT_W-1:0] low_len_q, low_len_d;
  logic             dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             edge_q, edge_d;
  logic             done_q, done_d;

  // Effective phase lengths of the requested burst (a zero length means one cycle).
  logic [CNT_W-1:0] high_eff;
  logic [CNT_W-1:0] low_eff;
  assign high_eff = (bus.high_len == '0) ? CNT_W'(1) : bus.high_len;
  assign low_eff  = (bus.low_len  == '0) ? CNT_W'(1) : bus.low_len;

  // Next-state, counter and output computation; outputs are derived from the
  // next state so that they appear registered one cycle after the decision.
  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    high_len_d  = high_len_q;
    low_len_d   = low_len_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          high_len_d  = high_eff;
          low_len_d   = low_eff;
          pulse_cnt_d = bus.num_pulses;
          if (bus.num_pulses == '0) begin
            // Empty burst: acknowledge without producing any edge.
            done_d = 1'b1;
          end else begin
            state_d     = HIGH;
            phase_cnt_d = high_eff - CNT_W'(1);
          end
        end
      end

      HIGH: begin
        if (bus.abort) begin
          state_d     = IDLE;
          phase_cnt_d = '0;
          pulse_cnt_d = '0;
        end else if (phase_cnt_q == '0) begin
          state_d     = LOW;
          phase_cnt_d = low_len_q - CNT_W'(1);
        end else begin
          phase_cnt_d = phase_cnt_q - CNT_W'(1);
        end
      end

      LOW: begin
        if (bus.abort) begin
          state_d     = IDLE;
          phase_cnt_d = '0;
          pulse_cnt_d = '0;
        end else if (phase_cnt_q == '0) begin
          pulse_cnt_d = pulse_cnt_q - NUM_W'(1);
          if (pulse_cnt_q == NUM_W'(1)) begin
            // Last low phase finished: dout is already low, no extra edge.
            state_d     = IDLE;
            phase_cnt_d = '0;
            done_d      = 1'b1;
          end else begin
            state_d     = HIGH;
            phase_cnt_d = high_len_q - CNT_W'(1);
          end
        end else begin
          phase_cnt_d = phase_cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d     = IDLE;
        phase_cnt_d = '0;
        pulse_cnt_d = '0;
      end
    endcase

    dout_d = (state_d == HIGH);
    busy_d = (state_d != IDLE);
    edge_d = dout_d ^ dout_q;
  end

  // State, counters, latched burst parameters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      phase_cnt_q <= '0;
      pulse_cnt_q <= '0;
      high_len_q  <= '0;
      low_len_q   <= '0;
      dout_q      <= 1'b0;
      busy_q      <= 1'b0;
      edge_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      high_len_q  <= high_len_d;
      low_len_q   <= low_len_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      edge_q      <= edge_d;
      done_q      <= done_d;
    end
  end

  assign bus.ready       = (state_q == IDLE);
  assign bus.busy        = busy_q;
  assign bus.dout        = dout_q;
  assign bus.edge_strobe = edge_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_edge_pattern_generator.sv
// Directed bench for edge_pattern_generator. Per-cycle outputs of a burst are
// collected into bit masks (bit c = cycle c after the accept edge) and
// compared against hand-computed masks.
module tb_edge_pattern_generator;
  localparam int CNT_W = 8;
  localparam int NUM_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  edge_pattern_generator_if #(.CNT_W(CNT_W), .NUM_W(NUM_W)) bus ();

  edge_pattern_generator #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Either-edge detector used for the loopback check: one cycle of latency.
  logic det_prev;
  logic det_edge;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      det_prev <= 1'b0;
      det_edge <= 1'b0;
    end else begin
      det_prev <= bus.dout;
      det_edge <= bus.dout ^ det_prev;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          h;
    int          l;
    int          n;
    int          len;        // cycles captured after the accept edge
    int          start_cyc;  // cycle with a second start (different params), 0 = none
    int          abort_cyc;  // cycle with abort asserted, 0 = none
    logic [31:0] exp_dout;
    logic [31:0] exp_strobe;
    logic [31:0] exp_busy;
    logic [31:0] exp_done;
    logic [31:0] exp_ready;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Present a request during one cycle so it is taken on the following edge.
  task automatic accept(input int h, input int l, input int n);
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.high_len   = CNT_W'(h);
    bus.low_len    = CNT_W'(l);
    bus.num_pulses = NUM_W'(n);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [31:0] m_dout, m_strobe, m_busy, m_done, m_ready;
    m_dout = '0; m_strobe = '0; m_busy = '0; m_done = '0; m_ready = '0;
    @(negedge clk);
    check($sformatf("vec%0d ready_before", idx), 32'(bus.ready), 32'd1);
    accept(v.h, v.l, v.n);
    for (int c = 1; c <= v.len; c++) begin
      bus.start = (c == v.start_cyc);
      if (c == v.start_cyc) begin
        bus.high_len   = CNT_W'(1);
        bus.low_len    = CNT_W'(1);
        bus.num_pulses = NUM_W'(1);
      end
      bus.abort = (c == v.abort_cyc);
      @(negedge clk);
      m_dout[c]   = bus.dout;
      m_strobe[c] = bus.edge_strobe;
      m_busy[c]   = bus.busy;
      m_done[c]   = bus.done;
      m_ready[c]  = bus.ready;
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check($sformatf("vec%0d dout", idx),   m_dout,   v.exp_dout);
    check($sformatf("vec%0d strobe", idx), m_strobe, v.exp_strobe);
    check($sformatf("vec%0d busy", idx),   m_busy,   v.exp_busy);
    check($sformatf("vec%0d done", idx),   m_done,   v.exp_done);
    check($sformatf("vec%0d ready", idx),  m_ready,  v.exp_ready);
  endtask

  initial begin
    logic [31:0] m_dout, m_strobe, m_busy, m_done, m_ready, m_det;
    int strobes, det_cnt;

    //        h  l  n len sc ac  dout      strobe     busy       done       ready
    vecs[0] = '{2, 3, 2, 12, 0, 0, 32'hC6,  32'h14A,  32'h7FE,  32'h800,  32'h1800};
    vecs[1] = '{5, 5, 0,  3, 0, 2, 32'h0,   32'h0,    32'h0,    32'h2,    32'hE};
    vecs[2] = '{0, 0, 3,  8, 0, 0, 32'h2A,  32'h7E,   32'h7E,   32'h80,   32'h180};
    vecs[3] = '{3, 1, 2, 10, 0, 0, 32'hEE,  32'h132,  32'h1FE,  32'h200,  32'h600};
    vecs[4] = '{1, 2, 1,  5, 0, 0, 32'h2,   32'h6,    32'hE,    32'h10,   32'h30};
    vecs[5] = '{4, 4, 5, 12, 3, 6, 32'h1E,  32'h22,   32'h7E,   32'h0,    32'h1F80};
    vecs[6] = '{4, 4, 2,  6, 0, 2, 32'h6,   32'hA,    32'h6,    32'h0,    32'h78};

    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.high_len   = '0;
    bus.low_len    = '0;
    bus.num_pulses = '0;
    #1;
    check("reset {dout,busy,strobe,done,ready}",
          32'({bus.dout, bus.busy, bus.edge_strobe, bus.done, bus.ready}), 32'b00001);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Reset in the middle of a burst (H=3, L=2, N=4), dropped during cycle 5.
    accept(3, 2, 4);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("midrst busy_before", 32'(bus.busy), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("midrst {dout,busy,strobe,done,ready}",
          32'({bus.dout, bus.busy, bus.edge_strobe, bus.done, bus.ready}), 32'b00001);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_done = '0; m_busy = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      m_done[c] = bus.done;
      m_busy[c] = bus.busy;
    end
    check("midrst done_after", m_done, 32'h0);
    check("midrst busy_after", m_busy, 32'h0);

    for (int i = 0; i < 7; i++) begin
      run_vec(i, vecs[i]);
    end

    // Back-to-back bursts (H=1, L=1, N=3), second accepted in the done cycle,
    // with dout looped into the either-edge detector.
    m_dout = '0; m_strobe = '0; m_busy = '0; m_done = '0; m_ready = '0; m_det = '0;
    accept(1, 1, 3);
    for (int c = 1; c <= 16; c++) begin
      bus.start = (c == 7);
      @(negedge clk);
      m_dout[c]   = bus.dout;
      m_strobe[c] = bus.edge_strobe;
      m_busy[c]   = bus.busy;
      m_done[c]   = bus.done;
      m_ready[c]  = bus.ready;
      m_det[c]    = det_edge;
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    check("b2b dout",   m_dout,   32'h152A);
    check("b2b strobe", m_strobe, 32'h3F7E);
    check("b2b busy",   m_busy,   32'h3F7E);
    check("b2b done",   m_done,   32'h4080);
    check("b2b ready",  m_ready,  32'h1C080);
    check("b2b detector_edges", m_det, 32'h7EFC);
    strobes = $countones(m_strobe);
    det_cnt = $countones(m_det);
    check("b2b strobe_count",   32'(strobes), 32'd12);
    check("b2b detector_count", 32'(det_cnt), 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
